// File: rtl/pe_row_drain.sv
// Result drain for a systolic PE row: counts MAC beats, lets the FMA pipe settle,
// snapshots every PE result into a shadow buffer and streams it out (optional ReLU via PE_DRAIN_RELU_EN).
module pe_row_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PE     = 16,
    parameter int ACC_LEN    = 16,
    parameter int PIPE_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [NUM_PE*DATA_WIDTH-1:0]  pe_result,
    output logic                          pe_clear,
    output logic                          stall,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_PE)-1:0]     out_index,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    localparam int IDX_W = $clog2(NUM_PE);
    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam int FL_W  = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACC     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    state_t                          state_r;
    state_t                          state_s;
    logic [CNT_W-1:0]                beat_cnt_r;
    logic [CNT_W-1:0]                beat_cnt_s;
    logic [FL_W-1:0]                 flush_cnt_r;
    logic [FL_W-1:0]                 flush_cnt_s;
    logic                            pe_clear_r;
    logic                            busy_r;
    logic                            stall_r;
    logic                            full_r;
    logic [IDX_W-1:0]                idx_r;
    logic [NUM_PE*DATA_WIDTH-1:0]    shadow_r;
    logic                            hs_s;
    logic                            at_last_s;
    logic                            last_hs_s;
    logic [DATA_WIDTH-1:0]           word_s;
    logic [DATA_WIDTH-1:0]           out_data_s;

    assign hs_s      = full_r & out_ready;
    assign at_last_s = (idx_r == IDX_W'(NUM_PE - 1));
    assign last_hs_s = hs_s & at_last_s;

    // State, beat counter and flush counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            beat_cnt_r  <= beat_cnt_s;
            flush_cnt_r <= flush_cnt_s;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_s     = state_r;
        beat_cnt_s  = beat_cnt_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_ACC;
                    beat_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (in_valid && !stall_r) begin
                    if (beat_cnt_r == CNT_W'(ACC_LEN - 1)) begin
                        state_s     = ST_FLUSH;
                        beat_cnt_s  = CNT_W'(ACC_LEN);
                        flush_cnt_s = '0;
                    end else begin
                        beat_cnt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FL_W'(PIPE_LAT - 1)) begin
                    state_s = full_r ? ST_WAIT : ST_CAPTURE;
                end else begin
                    flush_cnt_s = flush_cnt_r + FL_W'(1);
                end
            end
            ST_WAIT: begin
                // The final handshake frees the buffer at this same edge.
                if (!full_r || last_hs_s) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            stall_r    <= 1'b0;
            pe_clear_r <= 1'b0;
        end else begin
            busy_r     <= (state_s != ST_IDLE);
            stall_r    <= (state_s == ST_FLUSH) || (state_s == ST_WAIT) || (state_s == ST_CAPTURE);
            pe_clear_r <= (state_r == ST_CAPTURE);
        end
    end

    // Shadow buffer capture and drain index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r   <= 1'b0;
            idx_r    <= '0;
            shadow_r <= '0;
        end else if (state_r == ST_CAPTURE) begin
            shadow_r <= pe_result;
            full_r   <= 1'b1;
            idx_r    <= '0;
        end else if (hs_s) begin
            if (at_last_s) begin
                full_r <= 1'b0;
                idx_r  <= '0;
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            full_r <= full_r;
            idx_r  <= idx_r;
        end
    end

    // Output word select, zero while the buffer is empty
    always_comb begin
        word_s     = shadow_r[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
        out_data_s = '0;
        if (full_r) begin
`ifdef PE_DRAIN_RELU_EN
            // Any word with the sign bit set (incl. -0.0 and negative NaN) clamps to zero.
            if (word_s[DATA_WIDTH-1]) begin
                out_data_s = '0;
            end else begin
                out_data_s = word_s;
            end
`else
            out_data_s = word_s;
`endif
        end else begin
            out_data_s = '0;
        end
    end

    assign pe_clear  = pe_clear_r;
    assign stall     = stall_r;
    assign busy      = busy_r;
    assign out_data  = out_data_s;
    assign out_index = idx_r;
    assign out_valid = full_r;
    assign out_last  = full_r & at_last_s;

endmodule
